// File: rtl/rtl_simd_add_stream_chain_if.sv
// ----------------------------------------------------------------------------
// rtl_simd_add_stream_chain_if
// Groups the ap_ctrl_chain handshake, the two input FIFO read ports and the
// output FIFO write port of rtl_simd_add_stream_chain.
//   master : the surrounding dataflow region (drives start/continue/ce, the
//            input FIFO data/empty flags and the output FIFO full flag)
//   slave  : the adder block itself
// Parameters: W = lane width, NCH = lanes per stream word.
// ----------------------------------------------------------------------------
interface rtl_simd_add_stream_chain_if #(
  parameter int W   = 11,
  parameter int NCH = 4
);
  logic             ap_ce;
  logic             ap_start;
  logic             ap_continue;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [NCH*W-1:0] artl;
  logic             artl_empty_n;
  logic             artl_read;
  logic [NCH*W-1:0] brtl;
  logic             brtl_empty_n;
  logic             brtl_read;
  logic [NCH*W-1:0] z;
  logic             z_full_n;
  logic             z_write;

  modport master (
    output ap_ce, ap_start, ap_continue,
    output artl, artl_empty_n, brtl, brtl_empty_n, z_full_n,
    input  ap_done, ap_idle, ap_ready, artl_read, brtl_read, z, z_write
  );

  modport slave (
    input  ap_ce, ap_start, ap_continue,
    input  artl, artl_empty_n, brtl, brtl_empty_n, z_full_n,
    output ap_done, ap_idle, ap_ready, artl_read, brtl_read, z, z_write
  );
endinterface

// File: rtl/rtl_simd_add_stream_chain.sv
// ----------------------------------------------------------------------------
// rtl_simd_add_stream_chain
// Streaming SIMD adder with an ap_ctrl_chain handshake. Each transaction pops
// NWORDS word pairs from FIFO streams A and B, adds the NCH packed W-bit lanes
// independently, and pushes NWORDS result words through a two-stage,
// stall-able pipeline (s1 = sum register, s2 = output register z).
//
// Ports:
//   ap_clk  - clock
//   ap_rst  - asynchronous, active-high reset
//   bus     - rtl_simd_add_stream_chain_if.slave:
//             ap_ce/ap_start/ap_continue in, ap_done/ap_idle/ap_ready out,
//             artl/artl_empty_n in, artl_read out,
//             brtl/brtl_empty_n in, brtl_read out,
//             z/z_write out, z_full_n in
//
// Build option: define SIMD_SAT_EN to treat lanes as signed two's complement
// with saturating addition; otherwise lanes wrap modulo 2^W.
// ----------------------------------------------------------------------------
module rtl_simd_add_stream_chain #(
  parameter int W      = 11,
  parameter int NCH    = 4,
  parameter int NWORDS = 5
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  rtl_simd_add_stream_chain_if.slave   bus
);

  localparam int              DW      = NCH * W;
  localparam int              CW      = $clog2(NWORDS + 1);
  localparam logic [CW-1:0]   LAST_RD = CW'(NWORDS - 1);
  localparam logic [CW-1:0]   ALL_WR  = CW'(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   s1_data_q, s1_data_d;
  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   z_q, z_d;
  logic            ap_ready_q, ap_ready_d;

  logic [DW-1:0]   lane_sum;
  logic            stall;
  logic            fire;
  logic            z_push;
  logic            s2_load;
  logic            last_rd;
  logic            drained;

  // Per-lane add; the saturating build clamps when both operands share a
  // sign and the wrapped result does not.
  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
`ifdef SIMD_SAT_EN
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))
      s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return s;
  endfunction

  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    lane_sum = '0;
    for (int i = 0; i < NCH; i++)
      lane_sum[i*W +: W] = lane_add(bus.artl[i*W +: W], bus.brtl[i*W +: W]);
  end

  // Flow control. A new word may enter s1 unless both stages are full and
  // the output FIFO refuses, which bounds the pipeline to two words.
  always_comb begin
    stall   = s1_valid_q && s2_valid_q && !bus.z_full_n;
    fire    = (state_q == S_RUN) && bus.artl_empty_n && bus.brtl_empty_n
              && !stall && bus.ap_ce;
    z_push  = s2_valid_q && bus.z_full_n && bus.ap_ce;
    s2_load = s1_valid_q && (!s2_valid_q || z_push);
    last_rd = fire && (rd_cnt_q == LAST_RD);
    drained = (wr_cnt_q == ALL_WR) && !s1_valid_q && !s2_valid_q;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      state_q <= S_IDLE;
    else if (bus.ap_ce)
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.ap_start)    state_d = S_RUN;
      S_RUN:   if (last_rd)         state_d = S_DRAIN;
      S_DRAIN: if (drained)         state_d = S_DONE;
      S_DONE:  if (bus.ap_continue) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // ap_ready is registered one cycle after the last read; masking with ap_ce
  // defers the visible pulse until the clock is enabled again.
  always_comb begin
    bus.ap_idle   = (state_q == S_IDLE);
    bus.ap_done   = (state_q == S_DONE);
    bus.ap_ready  = ap_ready_q && bus.ap_ce;
    bus.artl_read = fire;
    bus.brtl_read = fire;
    bus.z_write   = z_push;
    bus.z         = z_q;
  end

  // ---------------- Counters and pipeline next state ----------------
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    ap_ready_d = last_rd;

    if ((state_q == S_IDLE) && bus.ap_start) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end
    if (fire)   rd_cnt_d = rd_cnt_q + CW'(1);
    if (z_push) wr_cnt_d = wr_cnt_q + CW'(1);

    // s1 refills on fire; otherwise it empties when its word moves to s2.
    if (fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = lane_sum;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // z keeps its value whenever it is not reloaded, so it holds under
    // backpressure and retains the last result while idle.
    if (s2_load) begin
      s2_valid_d = 1'b1;
      z_d        = s1_data_q;
    end else if (z_push) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      ap_ready_q <= 1'b0;
    end else if (bus.ap_ce) begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      ap_ready_q <= ap_ready_d;
    end
  end

endmodule

// File: tb/tb_rtl_simd_add_stream_chain.sv
// ----------------------------------------------------------------------------
// tb_rtl_simd_add_stream_chain
// Self-checking bench for rtl_simd_add_stream_chain. Input FIFOs and the
// expected result stream are queues; expected words come from a lane-wise
// integer model of the add (wrap or signed saturation, matching the build).
// ----------------------------------------------------------------------------
module tb_rtl_simd_add_stream_chain;

  localparam int W      = 11;
  localparam int NCH    = 4;
  localparam int NWORDS = 5;
  localparam int DW     = NCH * W;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  rtl_simd_add_stream_chain_if #(.W(W), .NCH(NCH)) bus ();

  rtl_simd_add_stream_chain #(.W(W), .NCH(NCH), .NWORDS(NWORDS)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] a_q[$];
  logic [DW-1:0] b_q[$];
  logic [DW-1:0] exp_q[$];

  bit            a_en, b_en;
  int            cyc = 0;
  int            rd_total, wr_total, ready_cnt;
  int            first_rd_cyc, last_rd_cyc, first_wr_cyc, last_wr_cyc, ready_cyc;
  logic          s_done, s_idle, s_rd, s_wr;
  logic [DW-1:0] s_z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each lane added as plain integers, then wrapped or clamped.
  function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int ai, bi, s;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      ai = int'(a[i*W +: W]);
      bi = int'(b[i*W +: W]);
`ifdef SIMD_SAT_EN
      if (ai >= (1 << (W-1))) ai = ai - (1 << W);
      if (bi >= (1 << (W-1))) bi = bi - (1 << W);
      s = ai + bi;
      if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
      if (s < -(1 << (W-1)))    s = -(1 << (W-1));
`else
      s = (ai + bi) % (1 << W);
`endif
      r[i*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    return r;
  endfunction

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_q.push_back(a);
    b_q.push_back(b);
    exp_q.push_back(model_sum(a, b));
  endtask

  task automatic clear_queues();
    a_q.delete();
    b_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    bus.artl         = (a_q.size() > 0) ? a_q[0] : '0;
    bus.artl_empty_n = a_en && (a_q.size() > 0);
    bus.brtl         = (b_q.size() > 0) ? b_q[0] : '0;
    bus.brtl_empty_n = b_en && (b_q.size() > 0);
  endtask

  // One clock: present inputs, sample outputs mid-cycle, score, then apply
  // FIFO pops just after the active edge.
  task automatic tick();
    logic          rd_a, rd_b, wr, rdy;
    logic [DW-1:0] exp_w;
    drive_inputs();
    @(negedge ap_clk);
    cyc++;
    rd_a   = bus.artl_read;
    rd_b   = bus.brtl_read;
    wr     = bus.z_write;
    rdy    = bus.ap_ready;
    s_z    = bus.z;
    s_done = bus.ap_done;
    s_idle = bus.ap_idle;
    s_rd   = rd_a | rd_b;
    s_wr   = wr;
    if (rd_a || rd_b) begin
      check("read_pair", 64'(rd_b), 64'(rd_a));
      check("read_needs_data", 64'(bus.artl_empty_n && bus.brtl_empty_n && bus.ap_ce), 64'd1);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
    end
    if (wr) begin
      check("write_needs_room", 64'(bus.z_full_n && bus.ap_ce), 64'd1);
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("z_data", 64'(s_z), 64'(exp_w));
      wr_total++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (rdy) begin
      ready_cnt++;
      ready_cyc = cyc;
      check("ready_after_last_read", 64'(rd_total), 64'(NWORDS));
      check("ready_needs_ce", 64'(bus.ap_ce), 64'd1);
    end
    @(posedge ap_clk);
    #1;
    if (rd_a && a_q.size() > 0) void'(a_q.pop_front());
    if (rd_b && b_q.size() > 0) void'(b_q.pop_front());
    if (rd_a) begin
      rd_total++;
      check("in_flight_le_2", 64'((rd_total - wr_total) <= 2), 64'd1);
    end
  endtask

  task automatic reset_stats();
    rd_total = 0; wr_total = 0; ready_cnt = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; ready_cyc = -1;
  endtask

  // Modes: 0 plain, 1 basic timing, 2 literal first word, 3 backpressure,
  // 4 starvation, 5 clock-enable freeze, 9 random flow control.
  task automatic run_txn(input int mode, input bit has_lit, input logic [DW-1:0] lit,
                         input bit start_in_done);
    int  budget, stall_cnt, starve_cnt, ce_cnt, wr_before;
    bit  lit_done, stalled, starved, frozen;
    stall_cnt = 0; starve_cnt = 0; ce_cnt = 0; lit_done = 1'b0;
    reset_stats();
    a_en = 1'b1; b_en = 1'b1; bus.z_full_n = 1'b1; bus.ap_ce = 1'b1;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    budget = 400;
    while (!s_done && budget > 0) begin
      a_en = 1'b1; b_en = 1'b1; bus.z_full_n = 1'b1; bus.ap_ce = 1'b1;
      stalled = 1'b0; starved = 1'b0; frozen = 1'b0;
      wr_before = wr_total;
      case (mode)
        3: if (wr_total >= 1 && stall_cnt < 4) begin bus.z_full_n = 1'b0; stall_cnt++; stalled = 1'b1; end
        4: if (rd_total == 2 && starve_cnt < 3) begin b_en = 1'b0; starve_cnt++; starved = 1'b1; end
        5: if (rd_total == 2 && ce_cnt < 2) begin bus.ap_ce = 1'b0; ce_cnt++; frozen = 1'b1; end
        9: begin
          a_en         = ($urandom_range(0, 3) != 0);
          b_en         = ($urandom_range(0, 3) != 0);
          bus.z_full_n = ($urandom_range(0, 3) != 0);
          bus.ap_ce    = ($urandom_range(0, 7) != 0);
        end
        default: ;
      endcase
      tick();
      if (has_lit && !lit_done && wr_total == 1) begin
        check("first_word_value", 64'(s_z), 64'(lit));
        lit_done = 1'b1;
      end
      if (stalled) begin
        check("bp_z_held", 64'(s_z), 64'(exp_q[0]));
        check("bp_reads_stopped", 64'(rd_total), 64'd3);
      end
      if (starved) begin
        check("starve_no_read", 64'(rd_total), 64'd2);
        check("starve_no_ready", 64'(ready_cnt), 64'd0);
      end
      if (frozen) begin
        check("ce_no_read", 64'(rd_total), 64'd2);
        check("ce_no_write", 64'(wr_total), 64'(wr_before));
        check("ce_z_frozen", 64'(s_z), 64'(exp_q[0]));
      end
      budget--;
    end
    a_en = 1'b1; b_en = 1'b1; bus.z_full_n = 1'b1; bus.ap_ce = 1'b1;
    check("done_seen", 64'(s_done), 64'd1);
    check("reads", 64'(rd_total), 64'(NWORDS));
    check("writes", 64'(wr_total), 64'(NWORDS));
    check("ready_pulses", 64'(ready_cnt), 64'd1);
    if (mode == 1) begin
      check("latency", 64'(first_wr_cyc - first_rd_cyc), 64'd2);
      check("throughput", 64'(last_wr_cyc - first_wr_cyc), 64'(NWORDS - 1));
      check("ready_timing", 64'(ready_cyc - last_rd_cyc), 64'd1);
    end
    // DONE phase: ap_done held, optional ap_start must be ignored.
    bus.ap_start = start_in_done;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_held", 64'(s_done), 64'd1);
      check("not_idle_in_done", 64'(s_idle), 64'd0);
    end
    check("no_read_in_done", 64'(rd_total), 64'(NWORDS));
    bus.ap_start    = 1'b0;
    bus.ap_continue = 1'b1;
    tick();
    bus.ap_continue = 1'b0;
    tick();
    check("done_cleared", 64'(s_done), 64'd0);
    check("idle_after_continue", 64'(s_idle), 64'd1);
    tick();
    check("idle_stays", 64'(s_idle), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    ap_rst           = 1'b1;
    bus.ap_ce        = 1'b1;
    bus.ap_start     = 1'b0;
    bus.ap_continue  = 1'b0;
    bus.z_full_n     = 1'b1;
    bus.artl         = '0;
    bus.brtl         = '0;
    bus.artl_empty_n = 1'b0;
    bus.brtl_empty_n = 1'b0;
    a_en = 1'b1; b_en = 1'b1;
    reset_stats();

    @(posedge ap_clk);
    #1;
    check("rst_idle", 64'(bus.ap_idle), 64'd1);
    check("rst_done", 64'(bus.ap_done), 64'd0);
    check("rst_ready", 64'(bus.ap_ready), 64'd0);
    check("rst_z", 64'(bus.z), 64'd0);

    // Test 1: basic; data already waiting when reset releases.
    for (int k = 0; k < NWORDS; k++)
      push_pair(pack4(1 + k, 2 + k, 3 + k, 4 + k), pack4(10 + k, 20 + k, 30 + k, 40 + k));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    tick();
    check("no_rw_after_reset", 64'({s_rd, s_wr}), 64'd0);
    run_txn(1, 1'b1, pack4(11, 22, 33, 44), 1'b0);

    // Test 2: lane overflow corners.
    push_pair(pack4(12'h7FF, 12'h400, 12'h3FF, 12'h005), pack4(12'h001, 12'h400, 12'h001, 12'h7FE));
    push_pair(pack4(12'h400, 12'h123, 12'h7FF, 12'h000), pack4(12'h7FF, 12'h0DD, 12'h7FF, 12'h000));
    for (int k = 2; k < NWORDS; k++) push_pair(rand_word(), rand_word());
`ifdef SIMD_SAT_EN
    run_txn(2, 1'b1, pack4(12'h000, 12'h400, 12'h3FF, 12'h003), 1'b0);
`else
    run_txn(2, 1'b1, pack4(12'h000, 12'h000, 12'h400, 12'h003), 1'b0);
`endif

    // Tests 3-5: backpressure, starvation, clock-enable freeze + start in DONE.
    for (int m = 3; m <= 5; m++) begin
      for (int k = 0; k < NWORDS; k++) push_pair(rand_word(), rand_word());
      run_txn(m, 1'b0, '0, (m == 5));
    end

    // Test 6: asynchronous reset mid-transaction.
    reset_stats();
    for (int k = 0; k < NWORDS; k++) push_pair(rand_word(), rand_word());
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    budget = 50;
    while (rd_total < 2 && budget > 0) begin
      tick();
      budget--;
    end
    check("rst_mid_reads", 64'(rd_total), 64'd2);
    #2;
    ap_rst = 1'b1;
    #1;
    check("rst_mid_idle", 64'(bus.ap_idle), 64'd1);
    check("rst_mid_done", 64'(bus.ap_done), 64'd0);
    check("rst_mid_z", 64'(bus.z), 64'd0);
    check("rst_mid_rw", 64'({bus.artl_read, bus.z_write, bus.ap_ready}), 64'd0);
    clear_queues();
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int k = 0; k < NWORDS; k++) push_pair(rand_word(), rand_word());
    tick();
    check("no_rw_after_reset2", 64'({s_rd, s_wr}), 64'd0);
    run_txn(0, 1'b0, '0, 1'b0);

    // Randomized flow control on all handshakes.
    for (int t = 0; t < 15; t++) begin
      for (int k = 0; k < NWORDS; k++) push_pair(rand_word(), rand_word());
      run_txn(9, 1'b0, '0, ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtl_simd_add_stream_chain.md
Name: rtl_simd_add_stream_chain

Overview:
Parametrised successor to the single-lane streaming blackbox adder. Adds NCH packed lanes of two FIFO-fed streams per word through a 2-stage stall-able pipeline, and emits NWORDS results per transaction. Full ap_ctrl_chain handshake with real FIFO flow control on both sides. Instantiated as an RTL blackbox inside HLS-generated dataflow regions.

Parameters:
W, 11, lane width in bits
NCH, 4, lanes packed per stream word
NWORDS, 5, words consumed/produced per ap_start transaction (>=1)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset, asynchronous, active-high
ap_ce  in  1  clock enable; low freezes all state
ap_start  in  1  begin transaction
ap_continue  in  1  acknowledge ap_done (ap_ctrl_chain)
ap_done  out  1  transaction complete, held until ap_continue
ap_idle  out  1  block idle
ap_ready  out  1  one-cycle pulse: last input word consumed
artl  in  NCH*W  stream A data, lane i at [i*W +: W]
artl_empty_n  in  1  stream A has data
artl_read  out  1  pop stream A
brtl  in  NCH*W  stream B data
brtl_empty_n  in  1  stream B has data
brtl_read  out  1  pop stream B
z  out  NCH*W  result data, registered
z_full_n  in  1  output FIFO can accept
z_write  out  1  push z

Behaviour:
- Reset: ap_rst clears asynchronously: FSM=IDLE, counters=0, both stage valids=0, z=0, ap_done=0, ap_ready=0; ap_idle=1 from reset. No read/write in the first cycle after deassertion.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: ap_idle=1. ap_start=1 -> RUN; rd_cnt, wr_cnt cleared.
- RUN: fire = artl_empty_n && brtl_empty_n && !stall && ap_ce; artl_read=brtl_read=fire (always equal; never pop one stream alone). rd_cnt++ on fire. The fire with rd_cnt==NWORDS-1 pulses ap_ready for the following cycle -> DRAIN.
- DRAIN: no reads. When wr_cnt==NWORDS and both stages empty -> DONE.
- DONE: ap_done=1. ap_continue=1 -> IDLE (ap_done drops next cycle). ap_start during DONE is ignored until IDLE.
- ap_start outside IDLE: ignored.
- Pipeline: s1 registers lane sums + valid on fire. s2 (= z register) takes s1 when s2 is empty or being written.
  - z_write = s2_valid && z_full_n && ap_ce; wr_cnt++ on each.
  - stall = s1_valid && s2_valid && !z_full_n.
  - Min latency: fire at cycle t -> z_write at t+2.
  - Full throughput: 1 word/cycle when no backpressure or starvation.
- Arithmetic: per lane, z_i = (a_i + b_i) mod 2^W, no carry between lanes.
- z holds its value while s2_valid && !z_full_n; z holds its last value when idle.
- ap_ce=0: no state change, artl_read=brtl_read=z_write=0, ap_ready pulse deferred.
- Backpressure: at most 2 words in flight; nothing lost or reordered.
- Reset mid-transaction: abandons it; in-flight words are discarded.

Optional Feature:
Macro SIMD_SAT_EN.
- Defined: lanes are signed two's complement; sum saturates to [-2^(W-1), 2^(W-1)-1].
- Undefined: wrap modulo 2^W (default).
- Ports, latency and handshake are identical in both builds.

Test Plan:
1. Basic (W=11, NCH=4, NWORDS=5), FIFOs always ready, lanes a={1,2,3,4}, b={10,20,30,40} -> z={11,22,33,44} 2 cycles after first read; 5 consecutive writes; ap_ready pulses once; ap_done held until ap_continue, then ap_idle=1.
2. Wrap, no macro: lane 0x7FF+0x001 -> 0x000; 0x400+0x400 -> 0x000. With SIMD_SAT_EN: 0x3FF+0x001 -> 0x3FF; 0x400+0x7FF -> 0x400; 0x005+0x7FE -> 0x003.
3. Backpressure: z_full_n=0 for 4 cycles after the first write -> reads stop after 2 words in flight, z stable, no z_write; on release all 5 words arrive in order, none duplicated.
4. Starvation: brtl_empty_n=0 on word 3 for 3 cycles -> artl_read=brtl_read=0 throughout, ap_ready not pulsed early; completes with 5 correct words.
5. ap_ce=0 for 2 cycles mid-RUN, and ap_start re-asserted in DONE -> counters, z and outputs frozen; second ap_start ignored until ap_continue returns FSM to IDLE.
6. ap_rst asserted asynchronously after 2 reads -> outputs cleared immediately; a new transaction after release yields exactly 5 fresh words.
